// File: rtl/uart_rx_param_if.sv
`timescale 1ns/1ps
// uart_rx_param_if
//   Consumer-side bundle of the UART receiver: received word with its
//   valid/ready handshake, sticky error flags with their clear pulse, and busy.
//   Parameter: DATA_BITS - width of data_out.
//   master : receiver side (drives data_out, data_valid, *_err, busy)
//   slave  : consumer side (drives data_ready, err_clear)
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 framing_err;
   logic                 parity_err;
   logic                 overrun_err;
   logic                 err_clear;
   logic                 busy;

   modport master (
      output data_out, data_valid, framing_err, parity_err, overrun_err, busy,
      input  data_ready, err_clear
   );

   modport slave (
      input  data_out, data_valid, framing_err, parity_err, overrun_err, busy,
      output data_ready, err_clear
   );
endinterface

// File: rtl/uart_rx_param_core.sv
`timescale 1ns/1ps
// uart_rx_param_core
//   Parametrised UART receiver: 2-flop synchroniser, free-running baud-tick
//   divider, oversampling frame FSM and a one-entry output buffer with a
//   valid/ready handshake. Framing, overrun and (optional) parity errors are
//   sticky until err_clear.
//   Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the
//   data bits (even when PARITY_ODD=0, odd when 1). Without it parity_err is 0.
// Ports
//   clk    : system clock, all logic on posedge
//   reset  : synchronous, active-high
//   rx     : asynchronous serial line, idle high
//   bus    : uart_rx_param_if.master (data_out, data_valid, data_ready,
//            framing_err, parity_err, overrun_err, err_clear, busy)
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low level on rx_s
// ST_START  | counting to mid start bit, then re-checking for a false start
// ST_DATA   | sampling DATA_BITS bits at mid-bit, LSB first
// ST_PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// ST_STOP   | sampling STOP_BITS stop bits; word committed on the last one
module uart_rx_param_core #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   uart_rx_param_if.master bus
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int BW      = 4;

   localparam logic [TW-1:0] TICK_LAST   = TW'(DIV - 1);
   localparam logic [SW-1:0] S_MID       = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_meta_d;
   logic                 rx_s_q, rx_s_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic                 tick;
   logic [SW-1:0]        s_cnt_q, s_cnt_d;
   logic [BW-1:0]        b_cnt_q, b_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 framing_q, framing_d;
   logic                 overrun_q, overrun_d;
   logic                 commit;
   logic                 framing_set;
`ifdef UART_RX_PARITY_EN
   logic                 parity_q, parity_d;
   logic                 parity_set;
`endif

   // Synchroniser and tick divider; the divider never restarts on frame
   // edges, so sampling phase jitters by up to one tick period.
   always_comb begin
      rx_meta_d  = rx;
      rx_s_d     = rx_meta_q;
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      s_cnt_d     = s_cnt_q;
      b_cnt_d     = b_cnt_q;
      shift_d     = shift_q;
      commit      = 1'b0;
      framing_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               s_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_cnt_q == S_MID) begin
                  s_cnt_d = '0;
                  b_cnt_d = '0;
                  state_d = rx_s_q ? ST_IDLE : ST_DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  if (b_cnt_q == B_DATA_LAST) begin
                     b_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     b_cnt_d = b_cnt_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d    = '0;
                  parity_set = ^shift_q ^ rx_s_q ^ PARITY_ODD[0];
                  state_d    = ST_STOP;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d     = '0;
                  framing_set = !rx_s_q;
                  // Leaving at mid stop bit lets a following start edge be caught.
                  if (b_cnt_q == B_STOP_LAST) begin
                     b_cnt_d = '0;
                     commit  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     b_cnt_d = b_cnt_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output buffer and sticky flags; a set event overrides err_clear.
   always_comb begin
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      framing_d    = bus.err_clear ? 1'b0 : framing_q;
      overrun_d    = bus.err_clear ? 1'b0 : overrun_q;
      if (commit) begin
         if (!data_valid_q || bus.data_ready) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (data_valid_q && bus.data_ready) begin
         data_valid_d = 1'b0;
      end
      if (framing_set) framing_d = 1'b1;
   end

`ifdef UART_RX_PARITY_EN
   always_comb begin
      parity_d = bus.err_clear ? 1'b0 : parity_q;
      if (parity_set) parity_d = 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         tick_cnt_q   <= '0;
         s_cnt_q      <= '0;
         b_cnt_q      <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         framing_q    <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= rx_meta_d;
         rx_s_q       <= rx_s_d;
         tick_cnt_q   <= tick_cnt_d;
         s_cnt_q      <= s_cnt_d;
         b_cnt_q      <= b_cnt_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         framing_q    <= framing_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.framing_err = framing_q;
   assign bus.overrun_err = overrun_q;
   assign bus.busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err  = parity_q;
`else
   // Parity sense has no effect without the parity stage.
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD[0];
   assign bus.parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param_core.sv
`timescale 1ns/1ps
module tb_uart_rx_param_core;

   localparam int CLK_FREQ   = 1_843_200;
   localparam int BAUD_RATE  = 115_200;
   localparam int OVERSAMPLE = 16;
   localparam int PARITY_ODD = 0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx8 = 1'b1;
   logic rx5 = 1'b1;

   always #5 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) bus8 ();
   uart_rx_param_if #(.DATA_BITS(5)) bus5 ();

   uart_rx_param_core #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PARITY_ODD)
   ) dut8 (
      .clk(clk), .reset(reset), .rx(rx8), .bus(bus8)
   );

   uart_rx_param_core #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
      .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(PARITY_ODD)
   ) dut5 (
      .clk(clk), .reset(reset), .rx(rx5), .bus(bus5)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Count cycles with data_valid high and remember the last word seen.
   int         v8_cnt = 0;
   int         v5_cnt = 0;
   logic [7:0] cap8 = '0;
   logic [4:0] cap5 = '0;
   always @(negedge clk) begin
      if (bus8.data_valid) begin
         v8_cnt <= v8_cnt + 1;
         cap8   <= bus8.data_out;
      end
      if (bus5.data_valid) begin
         v5_cnt <= v5_cnt + 1;
         cap5   <= bus5.data_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic par_bit(input logic [8:0] d, input int n);
      logic p;
      p = PARITY_ODD[0];
      for (int i = 0; i < n; i++) p = p ^ d[i];
      return p;
   endfunction

   // All stimulus tasks start and end on a negedge.
   task automatic drive_bit(input int which, input logic v);
      if (which == 5) rx5 = v;
      else            rx8 = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                             input logic par, input logic stop1, input logic stop2,
                             input int nstop);
      drive_bit(which, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(which, par);
`endif
      drive_bit(which, stop1);
      if (nstop == 2) drive_bit(which, stop2);
      if (which == 5) rx5 = 1'b1;
      else            rx8 = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus8.data_ready = 1'b1; bus8.err_clear = 1'b0;
      bus5.data_ready = 1'b1; bus5.err_clear = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (bus8.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out8: got %h want 00", bus8.data_out); end
      n_cmp++; if (bus8.data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid8: got %b want 0", bus8.data_valid); end
      n_cmp++; if ({bus8.framing_err, bus8.parity_err, bus8.overrun_err} !== 3'b000) begin n_bad++; $display("FAIL reset_err8: got %b want 000", {bus8.framing_err, bus8.parity_err, bus8.overrun_err}); end
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
      n_cmp++; if ({bus5.data_out, bus5.data_valid, bus5.framing_err, bus5.parity_err, bus5.overrun_err, bus5.busy} !== 10'b0) begin n_bad++; $display("FAIL reset_all5: got %b want 0", {bus5.data_out, bus5.data_valid, bus5.framing_err, bus5.parity_err, bus5.overrun_err, bus5.busy}); end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      int c0;
      bus8.data_ready = 1'b1;
      c0 = v8_cnt;
      send_frame(8, 9'h0A5, 8, par_bit(9'h0A5, 8), 1'b1, 1'b1, 1);
      repeat (4) @(negedge clk);
      n_cmp++; if (v8_cnt - c0 !== 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", v8_cnt - c0); end
      n_cmp++; if (cap8 !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", cap8); end
      n_cmp++; if (bus8.data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_popped: got %b want 0", bus8.data_valid); end
      n_cmp++; if ({bus8.framing_err, bus8.parity_err, bus8.overrun_err} !== 3'b000) begin n_bad++; $display("FAIL basic_err: got %b want 000", {bus8.framing_err, bus8.parity_err, bus8.overrun_err}); end
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", bus8.busy); end
   endtask

   task automatic test_false_start();
      int c0;
      c0 = v8_cnt;
      rx8 = 1'b0;
      repeat (5) @(negedge clk);
      rx8 = 1'b1;
      n_cmp++; if (bus8.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_during: got %b want 1", bus8.busy); end
      repeat (20) @(negedge clk);
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after: got %b want 0", bus8.busy); end
      n_cmp++; if (v8_cnt !== c0) begin n_bad++; $display("FAIL glitch_no_valid: got %0d want %0d", v8_cnt, c0); end
      n_cmp++; if ({bus8.framing_err, bus8.parity_err, bus8.overrun_err} !== 3'b000) begin n_bad++; $display("FAIL glitch_err: got %b want 000", {bus8.framing_err, bus8.parity_err, bus8.overrun_err}); end
   endtask

   task automatic test_framing();
      bus8.data_ready = 1'b0;
      send_frame(8, 9'h03C, 8, par_bit(9'h03C, 8), 1'b0, 1'b1, 1);
      repeat (20) @(negedge clk);
      n_cmp++; if (bus8.data_out !== 8'h3C) begin n_bad++; $display("FAIL framing_data: got %h want 3c", bus8.data_out); end
      n_cmp++; if (bus8.data_valid !== 1'b1) begin n_bad++; $display("FAIL framing_valid: got %b want 1", bus8.data_valid); end
      n_cmp++; if (bus8.framing_err !== 1'b1) begin n_bad++; $display("FAIL framing_flag: got %b want 1", bus8.framing_err); end
      n_cmp++; if (bus8.overrun_err !== 1'b0) begin n_bad++; $display("FAIL framing_overrun: got %b want 0", bus8.overrun_err); end
      bus8.err_clear = 1'b1;
      @(negedge clk);
      bus8.err_clear = 1'b0;
      n_cmp++; if (bus8.framing_err !== 1'b0) begin n_bad++; $display("FAIL framing_clear: got %b want 0", bus8.framing_err); end
      n_cmp++; if (bus8.data_valid !== 1'b1) begin n_bad++; $display("FAIL framing_clear_keeps_valid: got %b want 1", bus8.data_valid); end
      bus8.data_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus8.data_valid !== 1'b0) begin n_bad++; $display("FAIL framing_pop: got %b want 0", bus8.data_valid); end
      n_cmp++; if (bus8.data_out !== 8'h3C) begin n_bad++; $display("FAIL framing_hold_after_pop: got %h want 3c", bus8.data_out); end
   endtask

   task automatic test_back_to_back();
      bus8.data_ready = 1'b0;
      send_frame(8, 9'h011, 8, par_bit(9'h011, 8), 1'b1, 1'b1, 1);
      send_frame(8, 9'h022, 8, par_bit(9'h022, 8), 1'b1, 1'b1, 1);
      repeat (4) @(negedge clk);
      n_cmp++; if (bus8.data_out !== 8'h11) begin n_bad++; $display("FAIL overrun_keep_old: got %h want 11", bus8.data_out); end
      n_cmp++; if (bus8.data_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid: got %b want 1", bus8.data_valid); end
      n_cmp++; if (bus8.overrun_err !== 1'b1) begin n_bad++; $display("FAIL overrun_flag: got %b want 1", bus8.overrun_err); end
      n_cmp++; if (bus8.framing_err !== 1'b0) begin n_bad++; $display("FAIL overrun_framing: got %b want 0", bus8.framing_err); end
      bus8.data_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus8.data_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_pop: got %b want 0", bus8.data_valid); end
      bus8.err_clear = 1'b1;
      @(negedge clk);
      bus8.err_clear = 1'b0;
      n_cmp++; if (bus8.overrun_err !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b want 0", bus8.overrun_err); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int c0;
      bus8.data_ready = 1'b1;
      c0 = v8_cnt;
      send_frame(8, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1);
      repeat (4) @(negedge clk);
      n_cmp++; if (v8_cnt - c0 !== 1) begin n_bad++; $display("FAIL parity_ok_valid: got %0d want 1", v8_cnt - c0); end
      n_cmp++; if (cap8 !== 8'h07) begin n_bad++; $display("FAIL parity_ok_data: got %h want 07", cap8); end
      n_cmp++; if (bus8.parity_err !== 1'b0) begin n_bad++; $display("FAIL parity_ok_flag: got %b want 0", bus8.parity_err); end
      c0 = v8_cnt;
      send_frame(8, 9'h007, 8, 1'b0, 1'b1, 1'b1, 1);
      repeat (4) @(negedge clk);
      n_cmp++; if (v8_cnt - c0 !== 1) begin n_bad++; $display("FAIL parity_bad_valid: got %0d want 1", v8_cnt - c0); end
      n_cmp++; if (bus8.parity_err !== 1'b1) begin n_bad++; $display("FAIL parity_bad_flag: got %b want 1", bus8.parity_err); end
      bus8.err_clear = 1'b1;
      @(negedge clk);
      bus8.err_clear = 1'b0;
      n_cmp++; if (bus8.parity_err !== 1'b0) begin n_bad++; $display("FAIL parity_clear: got %b want 0", bus8.parity_err); end
   endtask
`endif

   task automatic test_five_bit_two_stop();
      int c0;
      bus5.data_ready = 1'b0;
      send_frame(5, 9'h015, 5, par_bit(9'h015, 5), 1'b1, 1'b0, 2);
      repeat (20) @(negedge clk);
      n_cmp++; if (bus5.data_out !== 5'h15) begin n_bad++; $display("FAIL five_data: got %h want 15", bus5.data_out); end
      n_cmp++; if (bus5.data_valid !== 1'b1) begin n_bad++; $display("FAIL five_valid: got %b want 1", bus5.data_valid); end
      n_cmp++; if (bus5.framing_err !== 1'b1) begin n_bad++; $display("FAIL five_framing: got %b want 1", bus5.framing_err); end
      // Abort a frame with reset partway through the data bits.
      drive_bit(5, 1'b0);
      drive_bit(5, 1'b0);
      drive_bit(5, 1'b1);
      n_cmp++; if (bus5.busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b want 1", bus5.busy); end
      reset = 1'b1;
      rx5 = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({bus5.data_out, bus5.data_valid, bus5.framing_err, bus5.overrun_err, bus5.busy} !== 9'b0) begin n_bad++; $display("FAIL midreset_outputs: got %b want 0", {bus5.data_out, bus5.data_valid, bus5.framing_err, bus5.overrun_err, bus5.busy}); end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++; if (bus5.data_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_no_commit: got %b want 0", bus5.data_valid); end
      bus5.data_ready = 1'b1;
      c0 = v5_cnt;
      send_frame(5, 9'h00A, 5, par_bit(9'h00A, 5), 1'b1, 1'b1, 2);
      repeat (4) @(negedge clk);
      n_cmp++; if (v5_cnt - c0 !== 1) begin n_bad++; $display("FAIL after_reset_valid: got %0d want 1", v5_cnt - c0); end
      n_cmp++; if (cap5 !== 5'h0A) begin n_bad++; $display("FAIL after_reset_data: got %h want 0a", cap5); end
      n_cmp++; if (bus5.framing_err !== 1'b0) begin n_bad++; $display("FAIL after_reset_framing: got %b want 0", bus5.framing_err); end
   endtask

   initial begin
      bus8.data_ready = 1'b1;
      bus8.err_clear  = 1'b0;
      bus5.data_ready = 1'b1;
      bus5.err_clear  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_frame();
      test_false_start();
      test_framing();
      repeat (10) @(negedge clk);
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_five_bit_two_stop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
